instrumented_adder_sequencer: RTL

//  Initiator side of the instrumented-adder measurement interface. Replaces manual LA poking by the management core.

---
 rtl/instrumented_adder_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/instrumented_adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instrumented_adder_sequencer
// Description : Initiator for the instrumented-adder measurement interface.
//               It takes one command (operands + run window), drives the
//               adder operands and the ring-oscillator clear/run controls,
//               times the run window, and captures the ring count and the
//               adder sum. The result, together with correctness and
//               saturation flags, is returned over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module instrumented_adder_sequencer #(
  parameter int WIDTH         = 32,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [WIN_W-1:0] cmd_window,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_clear,
  output logic             dut_run,
  input  logic [WIDTH-1:0] dut_count,
  input  logic [WIDTH-1:0] dut_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_count,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_match,
  output logic             res_saturated,
  output logic             busy
);

  // Settle counter holds SETTLE_CYCLES-1 down to 0.
  localparam int              SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [WIDTH-1:0] dut_a_q, dut_a_d;
  logic [WIDTH-1:0] dut_b_q, dut_b_d;
  logic [WIDTH-1:0] res_count_q, res_count_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_match_q, res_match_d;
  logic             res_saturated_q, res_saturated_d;

  logic             cmd_fire;
  logic             res_fire;
  logic             settle_done;
  logic [WIDTH-1:0] expected_sum;

  assign cmd_fire     = cmd_valid && (state_q == ST_IDLE);
  assign res_fire     = res_ready && (state_q == ST_DONE);
  assign settle_done  = (settle_cnt_q == '0);
  // Carry-out is deliberately dropped: the reference sum wraps like the adder.
  assign expected_sum = dut_a_q + dut_b_q;

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero window skips RUN entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cmd_fire) state_d = ST_LOAD;
      ST_LOAD:    if (settle_done) state_d = (win_cnt_q == '0) ? ST_STOP : ST_RUN;
      ST_RUN:     if (win_cnt_q == WIN_W'(1)) state_d = ST_STOP;
      ST_STOP:    if (settle_done) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    if (res_fire) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state so reset drops run/clear on the same edge.
  always_comb begin
    cmd_ready     = (state_q == ST_IDLE);
    busy          = (state_q != ST_IDLE);
    dut_clear     = (state_q == ST_LOAD);
    dut_run       = (state_q == ST_RUN);
    res_valid     = (state_q == ST_DONE);
    dut_a         = dut_a_q;
    dut_b         = dut_b_q;
    res_count     = res_count_q;
    res_sum       = res_sum_q;
    res_match     = res_match_q;
    res_saturated = res_saturated_q;
  end

  // Datapath next values: operand latch, window/settle timers, result capture.
  always_comb begin
    dut_a_d         = dut_a_q;
    dut_b_d         = dut_b_q;
    win_cnt_d       = win_cnt_q;
    settle_cnt_d    = settle_cnt_q;
    res_count_d     = res_count_q;
    res_sum_d       = res_sum_q;
    res_match_d     = res_match_q;
    res_saturated_d = res_saturated_q;

    if (cmd_fire) begin
      dut_a_d   = cmd_a;
      dut_b_d   = cmd_b;
      win_cnt_d = cmd_window;
    end

    if (state_q == ST_RUN) begin
      win_cnt_d = win_cnt_q - WIN_W'(1);
    end

    // Reload on every entry into LOAD or STOP, otherwise count down inside them.
    if ((state_d != state_q) && ((state_d == ST_LOAD) || (state_d == ST_STOP))) begin
      settle_cnt_d = SETTLE_LOAD;
    end else if (((state_q == ST_LOAD) || (state_q == ST_STOP)) && !settle_done) begin
      settle_cnt_d = settle_cnt_q - SET_W'(1);
    end

    if (state_q == ST_CAPTURE) begin
      res_count_d     = dut_count;
      res_sum_d       = dut_sum;
      res_match_d     = (dut_sum == expected_sum);
      res_saturated_d = &dut_count;
    end
  end

  // Datapath registers; reset discards any pending result and clears operands.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dut_a_q         <= '0;
      dut_b_q         <= '0;
      win_cnt_q       <= '0;
      settle_cnt_q    <= '0;
      res_count_q     <= '0;
      res_sum_q       <= '0;
      res_match_q     <= 1'b0;
      res_saturated_q <= 1'b0;
    end else begin
      dut_a_q         <= dut_a_d;
      dut_b_q         <= dut_b_d;
      win_cnt_q       <= win_cnt_d;
      settle_cnt_q    <= settle_cnt_d;
      res_count_q     <= res_count_d;
      res_sum_q       <= res_sum_d;
      res_match_q     <= res_match_d;
      res_saturated_q <= res_saturated_d;
    end
  end

endmodule
`default_nettype wire
